vortex_noc_ctrl_bridge: RTL and testbench



---
 rtl/vortex_noc_ctrl_bridge_if.sv | 52 +++++
 rtl/vortex_noc_ctrl_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_vortex_noc_ctrl_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vortex_noc_ctrl_bridge_if.sv
// NoC flit ports and AXI4-Lite control master signals of the Vortex control bridge.
// The bridge uses the master modport; the splitter/AFU side uses slave.
interface vortex_noc_ctrl_bridge_if #(
  parameter int NOC_DATA_WIDTH  = 64,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 32
);
  logic                       noc_in_val;
  logic [NOC_DATA_WIDTH-1:0]  noc_in_data;
  logic                       noc_in_rdy;
  logic                       noc_out_val;
  logic [NOC_DATA_WIDTH-1:0]  noc_out_data;
  logic                       noc_out_rdy;

  logic                       m_axi_ctrl_awvalid;
  logic                       m_axi_ctrl_awready;
  logic [CTRL_ADDR_WIDTH-1:0] m_axi_ctrl_awaddr;
  logic                       m_axi_ctrl_wvalid;
  logic                       m_axi_ctrl_wready;
  logic [CTRL_DATA_WIDTH-1:0] m_axi_ctrl_wdata;
  logic [3:0]                 m_axi_ctrl_wstrb;
  logic                       m_axi_ctrl_bvalid;
  logic                       m_axi_ctrl_bready;
  logic [1:0]                 m_axi_ctrl_bresp;
  logic                       m_axi_ctrl_arvalid;
  logic                       m_axi_ctrl_arready;
  logic [CTRL_ADDR_WIDTH-1:0] m_axi_ctrl_araddr;
  logic                       m_axi_ctrl_rvalid;
  logic                       m_axi_ctrl_rready;
  logic [CTRL_DATA_WIDTH-1:0] m_axi_ctrl_rdata;
  logic [1:0]                 m_axi_ctrl_rresp;

  modport master (
    input  noc_in_val, noc_in_data, output noc_in_rdy,
    output noc_out_val, noc_out_data, input noc_out_rdy,
    output m_axi_ctrl_awvalid, m_axi_ctrl_awaddr, input m_axi_ctrl_awready,
    output m_axi_ctrl_wvalid, m_axi_ctrl_wdata, m_axi_ctrl_wstrb, input m_axi_ctrl_wready,
    input  m_axi_ctrl_bvalid, m_axi_ctrl_bresp, output m_axi_ctrl_bready,
    output m_axi_ctrl_arvalid, m_axi_ctrl_araddr, input m_axi_ctrl_arready,
    input  m_axi_ctrl_rvalid, m_axi_ctrl_rdata, m_axi_ctrl_rresp, output m_axi_ctrl_rready
  );

  modport slave (
    output noc_in_val, noc_in_data, input noc_in_rdy,
    input  noc_out_val, noc_out_data, output noc_out_rdy,
    input  m_axi_ctrl_awvalid, m_axi_ctrl_awaddr, output m_axi_ctrl_awready,
    input  m_axi_ctrl_wvalid, m_axi_ctrl_wdata, m_axi_ctrl_wstrb, output m_axi_ctrl_wready,
    output m_axi_ctrl_bvalid, m_axi_ctrl_bresp, input m_axi_ctrl_bready,
    input  m_axi_ctrl_arvalid, m_axi_ctrl_araddr, output m_axi_ctrl_arready,
    output m_axi_ctrl_rvalid, m_axi_ctrl_rdata, m_axi_ctrl_rresp, input m_axi_ctrl_rready
  );
endinterface

// File: rtl/vortex_noc_ctrl_bridge.sv
// Bridges OpenPiton non-cacheable load/store packets to single 32-bit AXI4-Lite
// accesses on the Vortex AFU control slave and returns a two-flit ack packet.
module vortex_noc_ctrl_bridge #(
  parameter int         NOC_DATA_WIDTH  = 64,
  parameter int         CTRL_ADDR_WIDTH = 8,
  parameter int         CTRL_DATA_WIDTH = 32,
  parameter logic [7:0] MSG_NC_LOAD     = 8'd14,
  parameter logic [7:0] MSG_NC_STORE    = 8'd15,
  parameter logic [7:0] MSG_LOAD_ACK    = 8'd26,
  parameter logic [7:0] MSG_STORE_ACK   = 8'd27
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  vortex_noc_ctrl_bridge_if.master        bus,
  output logic                            err_pulse
);

  typedef enum logic [3:0] {
    RX_HDR, RX_ADDR, RX_SRC, RX_DATA, DRAIN, AW_W, B, AR, R, TX_HDR, TX_DATA
  } state_t;

  state_t state, state_next;
  state_t drain_tgt, drain_tgt_next;

  logic                       active;
  logic [7:0]                 len_q;
  logic                       is_store;
  logic [7:0]                 tag_q;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [33:0]                src_q;
  logic [CTRL_DATA_WIDTH-1:0] wdata_q;
  logic [CTRL_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                 resp_q;
  logic [7:0]                 drain_cnt;
  logic                       aw_done, w_done;

  logic                       drain_load;
  logic [7:0]                 drain_load_val;
  logic                       err_set;

  logic       in_fire, out_fire, aw_pend, w_pend, aw_fire, w_fire;
  logic [7:0] hdr_len, hdr_type;
  logic       hdr_ok;

  assign in_fire  = bus.noc_in_val && bus.noc_in_rdy;
  assign out_fire = bus.noc_out_val && bus.noc_out_rdy;
  assign aw_pend  = active && (state == AW_W) && !aw_done;
  assign w_pend   = active && (state == AW_W) && !w_done;
  assign aw_fire  = aw_pend && bus.m_axi_ctrl_awready;
  assign w_fire   = w_pend && bus.m_axi_ctrl_wready;
  assign hdr_len  = bus.noc_in_data[29:22];
  assign hdr_type = bus.noc_in_data[21:14];
  assign hdr_ok   = ((hdr_type == MSG_NC_LOAD)  && (hdr_len >= 8'd2)) ||
                    ((hdr_type == MSG_NC_STORE) && (hdr_len >= 8'd3));

  assign bus.m_axi_ctrl_awaddr = addr_q;
  assign bus.m_axi_ctrl_araddr = addr_q;
  assign bus.m_axi_ctrl_wdata  = wdata_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= RX_HDR;
    else           state <= state_next;
  end

  // All handshake outputs are held low until the first clock after reset release.
  always_comb begin
    state_next          = state;
    drain_tgt_next      = drain_tgt;
    drain_load          = 1'b0;
    drain_load_val      = 8'd0;
    err_set             = 1'b0;
    bus.noc_in_rdy      = 1'b0;
    bus.noc_out_val     = 1'b0;
    bus.noc_out_data    = '0;
    bus.m_axi_ctrl_awvalid = aw_pend;
    bus.m_axi_ctrl_wvalid  = w_pend;
    bus.m_axi_ctrl_wstrb   = w_pend ? 4'hF : 4'h0;
    bus.m_axi_ctrl_bready  = 1'b0;
    bus.m_axi_ctrl_arvalid = 1'b0;
    bus.m_axi_ctrl_rready  = 1'b0;
    if (active) begin
      case (state)
        RX_HDR: begin
          bus.noc_in_rdy = 1'b1;
          if (in_fire) begin
            if (hdr_ok) begin
              state_next = RX_ADDR;
            end else begin
              err_set = 1'b1;
              if (hdr_len != 8'd0) begin
                state_next     = DRAIN;
                drain_load     = 1'b1;
                drain_load_val = hdr_len;
                drain_tgt_next = RX_HDR;
              end
            end
          end
        end
        RX_ADDR: begin
          bus.noc_in_rdy = 1'b1;
          if (in_fire) state_next = RX_SRC;
        end
        RX_SRC: begin
          bus.noc_in_rdy = 1'b1;
          if (in_fire) begin
            if (is_store) begin
              state_next = RX_DATA;
            end else if (len_q == 8'd2) begin
              state_next = AR;
            end else begin
              state_next     = DRAIN;
              drain_load     = 1'b1;
              drain_load_val = len_q - 8'd2;
              drain_tgt_next = AR;
            end
          end
        end
        RX_DATA: begin
          bus.noc_in_rdy = 1'b1;
          if (in_fire) begin
            if (len_q == 8'd3) begin
              state_next = AW_W;
            end else begin
              state_next     = DRAIN;
              drain_load     = 1'b1;
              drain_load_val = len_q - 8'd3;
              drain_tgt_next = AW_W;
            end
          end
        end
        DRAIN: begin
          bus.noc_in_rdy = 1'b1;
          if (in_fire && (drain_cnt == 8'd1)) state_next = drain_tgt;
        end
        AW_W: begin
          if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = B;
        end
        B: begin
          bus.m_axi_ctrl_bready = 1'b1;
          if (bus.m_axi_ctrl_bvalid) state_next = TX_HDR;
        end
        AR: begin
          bus.m_axi_ctrl_arvalid = 1'b1;
          if (bus.m_axi_ctrl_arready) state_next = R;
        end
        R: begin
          bus.m_axi_ctrl_rready = 1'b1;
          if (bus.m_axi_ctrl_rvalid) state_next = TX_HDR;
        end
        TX_HDR: begin
          bus.noc_out_val  = 1'b1;
          bus.noc_out_data = {src_q, 8'd1, (is_store ? MSG_STORE_ACK : MSG_LOAD_ACK), tag_q, 6'd0};
          if (bus.noc_out_rdy) state_next = TX_DATA;
        end
        TX_DATA: begin
          bus.noc_out_val  = 1'b1;
          bus.noc_out_data = is_store ? '0 : {rdata_q, rdata_q};
          if (out_fire) begin
            state_next = RX_HDR;
            err_set    = (resp_q != 2'b00);
          end
        end
        default: state_next = RX_HDR;
      endcase
    end
  end

  // Packet fields, AXI payload and the AW/W acceptance flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      active    <= 1'b0;
      err_pulse <= 1'b0;
      len_q     <= '0;
      is_store  <= 1'b0;
      tag_q     <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      drain_cnt <= '0;
      drain_tgt <= RX_HDR;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      active    <= 1'b1;
      err_pulse <= err_set;
      drain_tgt <= drain_tgt_next;
      if (drain_load)                     drain_cnt <= drain_load_val;
      else if (state == DRAIN && in_fire) drain_cnt <= drain_cnt - 8'd1;
      if (in_fire) begin
        case (state)
          RX_HDR: begin
            len_q    <= hdr_len;
            is_store <= (hdr_type == MSG_NC_STORE);
            tag_q    <= bus.noc_in_data[13:6];
          end
          RX_ADDR: addr_q  <= {bus.noc_in_data[CTRL_ADDR_WIDTH-1:2], 2'b00};
          RX_SRC:  src_q   <= bus.noc_in_data[63:30];
          RX_DATA: wdata_q <= bus.noc_in_data[CTRL_DATA_WIDTH-1:0];
          default: ;
        endcase
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == AW_W && state_next == B) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == B && bus.m_axi_ctrl_bvalid) resp_q <= bus.m_axi_ctrl_bresp;
      if (state == R && bus.m_axi_ctrl_rvalid) begin
        rdata_q <= bus.m_axi_ctrl_rdata;
        resp_q  <= bus.m_axi_ctrl_rresp;
      end
    end
  end

endmodule

// File: tb/tb_vortex_noc_ctrl_bridge.sv
// Scoreboard bench for vortex_noc_ctrl_bridge: NoC packet driver, reactive
// AXI4-Lite slave with configurable delays, and NoC response monitor.
module tb_vortex_noc_ctrl_bridge;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic err_pulse;

  vortex_noc_ctrl_bridge_if #(.NOC_DATA_WIDTH(64), .CTRL_ADDR_WIDTH(8), .CTRL_DATA_WIDTH(32)) bus ();

  vortex_noc_ctrl_bridge dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .bus       (bus),
    .err_pulse (err_pulse)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_out[$];
  logic [7:0]  exp_aw[$];
  logic [31:0] exp_w[$];
  logic [7:0]  exp_ar[$];
  int exp_err = 0;
  int err_cnt = 0;
  int in_acc  = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int aw_hs = 0, w_hs = 0;
  bit aw_low_w_high = 0;
  int stall_req = 0, stall_seen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sendFlit(input logic [63:0] f);
    int t = 0;
    bus.noc_in_val  = 1'b1;
    bus.noc_in_data = f;
    while (!bus.noc_in_rdy && t < 100) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 100) checkOutput("in_timeout", 64'd1, 64'd0);
    else          in_acc++;
    @(negedge ap_clk);
    bus.noc_in_val = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] mtype, input logic [7:0] len, input logic [7:0] tag,
                               input logic [63:0] addr_flit, input logic [31:0] data);
    logic [63:0] hdr, src;
    bit ok, st;
    st  = (mtype == 8'd15);
    ok  = ((mtype == 8'd14) && (len >= 8'd2)) || (st && (len >= 8'd3));
    hdr = {$urandom, $urandom};
    hdr[29:22] = len;
    hdr[21:14] = mtype;
    hdr[13:6]  = tag;
    src = {$urandom, $urandom};
    if (!ok) begin
      exp_err++;
      sendFlit(hdr);
      for (int i = 0; i < len; i++) sendFlit({$urandom, $urandom});
      return;
    end
    if (st) begin
      exp_aw.push_back({addr_flit[7:2], 2'b00});
      exp_w.push_back(data);
      if (bresp_cfg != 2'b00) exp_err++;
    end else begin
      exp_ar.push_back({addr_flit[7:2], 2'b00});
      if (rresp_cfg != 2'b00) exp_err++;
    end
    exp_out.push_back({src[63:30], 8'd1, (st ? 8'd27 : 8'd26), tag, 6'd0});
    exp_out.push_back(st ? 64'd0 : {rdata_cfg, rdata_cfg});
    sendFlit(hdr);
    sendFlit(addr_flit);
    sendFlit(src);
    if (st) sendFlit({$urandom, data});
    for (int i = (st ? 3 : 2); i < len; i++) sendFlit({$urandom, $urandom});
  endtask

  task automatic waitDone();
    int t = 0;
    while (exp_out.size() != 0 && t < 300) begin
      @(negedge ap_clk);
      t++;
    end
    checkOutput("resp_drain", exp_out.size(), 0);
    repeat (3) @(negedge ap_clk);
    checkOutput("axi_pending", exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    checkOutput("err_count", err_cnt, exp_err);
  endtask

  // AXI slave: decides readies/valids at negedge; a handshake lands on the next posedge.
  initial begin
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_seen = 0, w_seen = 0, b_fire = 0, ar_seen = 0, r_fire = 0;
    bus.m_axi_ctrl_awready = 0; bus.m_axi_ctrl_wready = 0; bus.m_axi_ctrl_arready = 0;
    bus.m_axi_ctrl_bvalid = 0; bus.m_axi_ctrl_bresp = 0;
    bus.m_axi_ctrl_rvalid = 0; bus.m_axi_ctrl_rdata = 0; bus.m_axi_ctrl_rresp = 0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        bus.m_axi_ctrl_awready = 0; bus.m_axi_ctrl_wready = 0; bus.m_axi_ctrl_arready = 0;
        bus.m_axi_ctrl_bvalid = 0; bus.m_axi_ctrl_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; b_fire = 0; ar_seen = 0; r_fire = 0;
        continue;
      end
      if (b_fire) begin bus.m_axi_ctrl_bvalid = 0; b_fire = 0; aw_seen = 0; w_seen = 0; end
      if (aw_seen && w_seen && !bus.m_axi_ctrl_bvalid) begin
        if (b_cnt >= b_delay) begin
          bus.m_axi_ctrl_bvalid = 1; bus.m_axi_ctrl_bresp = bresp_cfg; b_cnt = 0;
        end else b_cnt++;
      end
      if (bus.m_axi_ctrl_bvalid && bus.m_axi_ctrl_bready) b_fire = 1;
      if (r_fire) begin bus.m_axi_ctrl_rvalid = 0; r_fire = 0; ar_seen = 0; end
      if (ar_seen && !bus.m_axi_ctrl_rvalid) begin
        if (r_cnt >= r_delay) begin
          bus.m_axi_ctrl_rvalid = 1; bus.m_axi_ctrl_rdata = rdata_cfg;
          bus.m_axi_ctrl_rresp = rresp_cfg; r_cnt = 0;
        end else r_cnt++;
      end
      if (bus.m_axi_ctrl_rvalid && bus.m_axi_ctrl_rready) r_fire = 1;
      if (!bus.m_axi_ctrl_awvalid && bus.m_axi_ctrl_wvalid) aw_low_w_high = 1;
      bus.m_axi_ctrl_awready = bus.m_axi_ctrl_awvalid && (aw_cnt >= aw_delay);
      if (bus.m_axi_ctrl_awvalid && !bus.m_axi_ctrl_awready) aw_cnt++;
      if (bus.m_axi_ctrl_awvalid && bus.m_axi_ctrl_awready) begin
        aw_hs++; aw_seen = 1; aw_cnt = 0;
        if (exp_aw.size() == 0) checkOutput("aw_unexpected", 64'd1, 64'd0);
        else checkOutput("awaddr", bus.m_axi_ctrl_awaddr, exp_aw.pop_front());
      end
      bus.m_axi_ctrl_wready = bus.m_axi_ctrl_wvalid && (w_cnt >= w_delay);
      if (bus.m_axi_ctrl_wvalid && !bus.m_axi_ctrl_wready) w_cnt++;
      if (bus.m_axi_ctrl_wvalid && bus.m_axi_ctrl_wready) begin
        w_hs++; w_seen = 1; w_cnt = 0;
        if (exp_w.size() == 0) checkOutput("w_unexpected", 64'd1, 64'd0);
        else checkOutput("wstrb_wdata", {bus.m_axi_ctrl_wstrb, bus.m_axi_ctrl_wdata}, {4'hF, exp_w.pop_front()});
      end
      bus.m_axi_ctrl_arready = bus.m_axi_ctrl_arvalid && (ar_cnt >= ar_delay);
      if (bus.m_axi_ctrl_arvalid && !bus.m_axi_ctrl_arready) ar_cnt++;
      if (bus.m_axi_ctrl_arvalid && bus.m_axi_ctrl_arready) begin
        ar_seen = 1; ar_cnt = 0;
        if (exp_ar.size() == 0) checkOutput("ar_unexpected", 64'd1, 64'd0);
        else checkOutput("araddr", bus.m_axi_ctrl_araddr, exp_ar.pop_front());
      end
    end
  end

  // Response monitor: optional back-pressure, scoreboard compare, err_pulse count.
  initial begin
    logic [63:0] held = '0;
    bit stalled = 0;
    bus.noc_out_rdy = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin bus.noc_out_rdy = 1'b1; stalled = 0; continue; end
      if (err_pulse) err_cnt++;
      if (bus.noc_out_val && stall_req > 0) begin
        bus.noc_out_rdy = 1'b0;
        if (stalled) checkOutput("out_stable", bus.noc_out_data, held);
        checkOutput("in_rdy_stall", bus.noc_in_rdy, 1'b0);
        held = bus.noc_out_data;
        stalled = 1;
        stall_req--;
        stall_seen++;
      end else begin
        bus.noc_out_rdy = 1'b1;
        stalled = 0;
      end
      if (bus.noc_out_val && bus.noc_out_rdy) begin
        if (exp_out.size() == 0) checkOutput("out_unexpected", bus.noc_out_data, 64'd0);
        else checkOutput("out_flit", bus.noc_out_data, exp_out.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int snap_a, snap_b;
    bus.noc_in_val  = 1'b0;
    bus.noc_in_data = '0;
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    checkOutput("rst_ctrl", {bus.noc_in_rdy, bus.noc_out_val, bus.m_axi_ctrl_awvalid, bus.m_axi_ctrl_wvalid,
                             bus.m_axi_ctrl_bready, bus.m_axi_ctrl_arvalid, bus.m_axi_ctrl_rready, err_pulse}, 8'h00);
    checkOutput("rst_data", bus.noc_out_data, 64'd0);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    checkOutput("idle_in_rdy", bus.noc_in_rdy, 1'b1);

    $display("[TB] store L=3, immediate slave");
    applyStimulus(8'd15, 8'd3, 8'h5A, 64'hCAFE_0000_0000_00A7, 32'hDEADBEEF);
    waitDone();

    $display("[TB] load L=2, three R wait cycles");
    r_delay = 3; rdata_cfg = 32'h12345678;
    applyStimulus(8'd14, 8'd2, 8'h21, 64'h0000_0000_0000_0010, 32'h0);
    waitDone();

    $display("[TB] awready two cycles before wready");
    r_delay = 0; aw_delay = 0; w_delay = 2; aw_low_w_high = 0;
    snap_a = aw_hs; snap_b = w_hs;
    applyStimulus(8'd15, 8'd3, 8'h33, 64'h0000_0000_0000_003C, 32'hA5A55A5A);
    waitDone();
    checkOutput("aw_hs_once", aw_hs - snap_a, 1);
    checkOutput("w_hs_once", w_hs - snap_b, 1);
    checkOutput("aw_low_w_high", aw_low_w_high, 1'b1);
    w_delay = 0; aw_delay = 2; snap_a = aw_hs; snap_b = w_hs;
    applyStimulus(8'd15, 8'd3, 8'h34, 64'h0000_0000_0000_00F1, 32'h0BADF00D);
    waitDone();
    checkOutput("aw_hs_once_rev", aw_hs - snap_a, 1);
    checkOutput("w_hs_once_rev", w_hs - snap_b, 1);
    aw_delay = 0;

    $display("[TB] dropped packets");
    snap_a = in_acc;
    applyStimulus(8'h05, 8'd4, 8'h01, 64'h0, 32'h0);
    waitDone();
    checkOutput("drop_unknown_flits", in_acc - snap_a, 5);
    snap_a = in_acc;
    applyStimulus(8'h00, 8'd0, 8'h02, 64'h0, 32'h0);
    applyStimulus(8'd14, 8'd1, 8'h03, 64'h0, 32'h0);
    applyStimulus(8'd15, 8'd2, 8'h04, 64'h0, 32'h0);
    waitDone();
    checkOutput("drop_short_flits", in_acc - snap_a, 1 + 2 + 3);

    $display("[TB] packets with extra payload flits");
    rdata_cfg = $urandom;
    applyStimulus(8'd14, 8'd4, 8'h44, 64'h0000_0000_0000_0022, 32'h0);
    applyStimulus(8'd15, 8'd5, 8'h55, 64'h0000_0000_0000_00FF, 32'h13579BDF);
    waitDone();

    $display("[TB] output back-pressure and SLVERR");
    stall_seen = 0; stall_req = 5; bresp_cfg = 2'b10; b_delay = 1;
    applyStimulus(8'd15, 8'd3, 8'h66, 64'h0000_0000_0000_0008, 32'h00C0FFEE);
    waitDone();
    checkOutput("stall_cycles", stall_seen, 5);
    bresp_cfg = 2'b00; b_delay = 0;

    $display("[TB] reset during R with rvalid pending");
    r_delay = 2; rdata_cfg = 32'hFEEDFACE;
    applyStimulus(8'd14, 8'd2, 8'h77, 64'h0000_0000_0000_0030, 32'h0);
    t = 0;
    do begin
      @(negedge ap_clk); #1; t++;
    end while (!(bus.m_axi_ctrl_rvalid && bus.m_axi_ctrl_rready) && t < 60);
    checkOutput("r_pending", {bus.m_axi_ctrl_rvalid, bus.m_axi_ctrl_rready}, 2'b11);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", {bus.noc_in_rdy, bus.noc_out_val, bus.m_axi_ctrl_awvalid, bus.m_axi_ctrl_wvalid,
                                   bus.m_axi_ctrl_bready, bus.m_axi_ctrl_arvalid, bus.m_axi_ctrl_rready, err_pulse}, 8'h00);
    checkOutput("async_rst_addr", {bus.m_axi_ctrl_awaddr, bus.m_axi_ctrl_araddr, bus.m_axi_ctrl_wdata, bus.m_axi_ctrl_wstrb}, 64'd0);
    checkOutput("async_rst_data", bus.noc_out_data, 64'd0);
    exp_out.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    r_delay = 0; rdata_cfg = 32'h0F0F1234;
    applyStimulus(8'd14, 8'd2, 8'h78, 64'h0000_0000_0000_0034, 32'h0);
    applyStimulus(8'd15, 8'd3, 8'h79, 64'h0000_0000_0000_0050, 32'h89ABCDEF);
    waitDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
